// File: rtl/reset_seq_pkg.sv
// reset_seq_pkg: shared state encoding and status widths for the reset sequencer.
package reset_seq_pkg;
    localparam logic [2:0] PLL_RST     = 3'd0;
    localparam logic [2:0] WAIT_LOCK   = 3'd1;
    localparam logic [2:0] LOCK_STABLE = 3'd2;
    localparam logic [2:0] SOC_RST     = 3'd3;
    localparam logic [2:0] RUN         = 3'd4;
    localparam int FAIL_W = 8;
    localparam logic [FAIL_W-1:0] FAIL_MAX = '1;
endpackage

// File: rtl/reset_sequencer_if.sv
// reset_sequencer_if: board-side signals between button, clock wizard, SoC and the sequencer.
interface reset_sequencer_if;
    import reset_seq_pkg::*;
    logic btn_n;
    logic pll_locked;
    logic pll_reset;
    logic soc_reset;
    logic ready;
    logic lock_lost;
    logic [FAIL_W-1:0] fail_count;
    modport master (
        input  btn_n, pll_locked,
        output pll_reset, soc_reset, ready, fail_count, lock_lost
    );
    modport slave (
        output btn_n, pll_locked,
        input  pll_reset, soc_reset, ready, fail_count, lock_lost
    );
endinterface

// File: rtl/reset_sequencer_debounce.sv
// reset_sequencer_debounce: synchronises the raw button and accepts a new level only
// after it has been stable for DEBOUNCE_CYCLES consecutive cycles.
module reset_sequencer_debounce #(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_n,
    output logic btn_db
);
    localparam int W = $clog2(DEBOUNCE_CYCLES + 1);
    logic [1:0] sync;
    logic [W-1:0] cnt;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync   <= 2'b11;
            cnt    <= '0;
            btn_db <= 1'b1;
        end else begin
            sync <= {sync[0], btn_n};
            if (sync[1] == btn_db)
                cnt <= '0;
            else if (cnt == W'(DEBOUNCE_CYCLES - 1)) begin
                cnt    <= '0;
                btn_db <= sync[1];
            end else
                cnt <= cnt + W'(1);
        end
    end
endmodule

// File: rtl/reset_sequencer.sv
// reset_sequencer: PLL reset pulse, lock qualification and timed SoC reset release,
// running on the free-running board clock so it survives PLL loss.
module reset_sequencer
    import reset_seq_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES     = 1000000,
    parameter int PLL_RST_CYCLES      = 1000,
    parameter int LOCK_STABLE_CYCLES  = 100000,
    parameter int SOC_RST_CYCLES      = 256,
    parameter int LOCK_TIMEOUT_CYCLES = 10000000,
    parameter int CNT_W               = 24
) (
    input logic clk,
    input logic reset,
    reset_sequencer_if.master bus
);
    logic btn_db;
    logic [1:0] lock_sync;
    logic locked_s;
    logic [2:0] state, nxt_state;
    logic [CNT_W-1:0] cnt, nxt_cnt;
    logic [FAIL_W-1:0] nxt_fail;
    logic nxt_lost;

    assign locked_s = lock_sync[1];

    reset_sequencer_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_debounce (
        .clk    (clk),
        .reset  (reset),
        .btn_n  (bus.btn_n),
        .btn_db (btn_db)
    );

    always_comb begin
        nxt_state = state;
        nxt_fail  = bus.fail_count;
        nxt_lost  = bus.lock_lost;
        if (!btn_db)
            nxt_state = PLL_RST;
        else
            case (state)
                PLL_RST:     nxt_state = cnt == CNT_W'(PLL_RST_CYCLES - 1) ? WAIT_LOCK : PLL_RST;
                WAIT_LOCK:
                    if (locked_s)
                        nxt_state = LOCK_STABLE;
                    else if (cnt == CNT_W'(LOCK_TIMEOUT_CYCLES - 1)) begin
                        nxt_state = PLL_RST;
                        nxt_fail  = bus.fail_count == FAIL_MAX ? FAIL_MAX : bus.fail_count + FAIL_W'(1);
                    end
                LOCK_STABLE: nxt_state = !locked_s ? WAIT_LOCK :
                                         cnt == CNT_W'(LOCK_STABLE_CYCLES - 1) ? SOC_RST : LOCK_STABLE;
                SOC_RST:     nxt_state = !locked_s ? PLL_RST :
                                         cnt == CNT_W'(SOC_RST_CYCLES - 1) ? RUN : SOC_RST;
                RUN:
                    if (!locked_s) begin
                        nxt_state = PLL_RST;
                        nxt_lost  = 1'b1;
                    end
                default:     nxt_state = PLL_RST;
            endcase
        // RUN has no timed exit, so its counter parks at zero instead of wrapping
        nxt_cnt = (!btn_db || nxt_state != state || state == RUN) ? '0 : cnt + CNT_W'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lock_sync      <= '0;
            state          <= PLL_RST;
            cnt            <= '0;
            bus.pll_reset  <= 1'b1;
            bus.soc_reset  <= 1'b1;
            bus.ready      <= 1'b0;
            bus.fail_count <= '0;
            bus.lock_lost  <= 1'b0;
        end else begin
            lock_sync      <= {lock_sync[0], bus.pll_locked};
            state          <= nxt_state;
            cnt            <= nxt_cnt;
            bus.pll_reset  <= nxt_state == PLL_RST;
            bus.soc_reset  <= nxt_state != RUN;
            bus.ready      <= nxt_state == RUN;
            bus.fail_count <= nxt_fail;
            bus.lock_lost  <= nxt_lost;
        end
    end
endmodule

// File: tb/tb_reset_sequencer.sv
// tb_reset_sequencer: directed scenarios; expected output changes (cycle + value) are queued
// by the stimulus and matched by a monitor whenever the DUT outputs change.
module tb_reset_sequencer;
    typedef struct packed {
        logic pll;
        logic soc;
        logic rdy;
        logic lost;
        logic [7:0] fail;
    } outs_t;
    typedef struct {
        int    cyc;
        outs_t o;
    } ev_t;

    localparam outs_t RST_O = '{pll: 1'b1, soc: 1'b1, rdy: 1'b0, lost: 1'b0, fail: 8'd0};

    logic clk = 1'b0;
    logic reset = 1'b1;
    int cyc = 0;
    int n_tests = 0;
    int n_fail = 0;
    ev_t q[$];
    outs_t e;

    reset_sequencer_if bus();

    reset_sequencer #(
        .DEBOUNCE_CYCLES(4), .PLL_RST_CYCLES(8), .LOCK_STABLE_CYCLES(16),
        .SOC_RST_CYCLES(4), .LOCK_TIMEOUT_CYCLES(64), .CNT_W(24)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic outs_t cur();
        return {bus.pll_reset, bus.soc_reset, bus.ready, bus.lock_lost, bus.fail_count};
    endfunction

    task automatic push(input int c);
        q.push_back('{cyc: c, o: e});
    endtask

    task automatic at(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    // Monitor: every observed output change must match the next queued expectation.
    initial begin
        outs_t prev, now;
        ev_t x;
        @(negedge clk);
        prev = cur();
        n_tests++;
        if (prev !== RST_O) begin
            n_fail++;
            $display("FAIL reset_state: got %h want %h", prev, RST_O);
        end
        forever begin
            @(negedge clk);
            now = cur();
            if (now !== prev) begin
                n_tests++;
                if (q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_change: cycle %0d outs %h (was %h)", cyc, now, prev);
                end else begin
                    x = q.pop_front();
                    if (x.cyc != cyc || x.o !== now) begin
                        n_fail++;
                        $display("FAIL event: got cycle %0d outs %h, want cycle %0d outs %h",
                                 cyc, now, x.cyc, x.o);
                    end
                end
                prev = now;
            end
        end
    end

    initial begin
        int r, d, l2, g, p, x, w0, k0, q0;
        bus.btn_n = 1'b1;
        bus.pll_locked = 1'b0;
        e = RST_O;
        repeat (3) @(negedge clk);
        // Cold boot: lock at +20, SoC released 2+1+16+4 = 23 cycles later
        reset = 1'b0;
        r = cyc;
        e.pll = 1'b0; push(r + 8);
        at(r + 20); bus.pll_locked = 1'b1;
        e.soc = 1'b0; e.rdy = 1'b1; push(r + 43);
        // Lock loss in RUN: 2 sync + 1 edge, then a full PLL reset period
        d = r + 48;
        at(d); bus.pll_locked = 1'b0;
        e.pll = 1'b1; e.soc = 1'b1; e.rdy = 1'b0; e.lost = 1'b1; push(d + 3);
        e.pll = 1'b0; push(d + 11);
        // Relock with a one-cycle dropout 10 cycles into LOCK_STABLE restarts qualification
        l2 = d + 15;
        at(l2); bus.pll_locked = 1'b1;
        at(l2 + 13); bus.pll_locked = 1'b0;
        at(l2 + 14); bus.pll_locked = 1'b1;
        e.soc = 1'b0; e.rdy = 1'b1; push(l2 + 37);
        // 3-cycle button glitch is rejected by the 4-cycle debounce
        g = l2 + 42;
        at(g); bus.btn_n = 1'b0;
        at(g + 3); bus.btn_n = 1'b1;
        // 10-cycle press: 2 sync + 4 debounce + registered state decode, then 8 PLL_RST cycles after release
        p = g + 15;
        at(p); bus.btn_n = 1'b0;
        e.pll = 1'b1; e.soc = 1'b1; e.rdy = 1'b0; push(p + 7);
        at(p + 10); bus.btn_n = 1'b1;
        e.pll = 1'b0; push(p + 24);
        e.soc = 1'b0; e.rdy = 1'b1; push(p + 45);
        // Lock never returns: timeouts every 64+8 cycles, fail_count saturates at 255
        x = p + 50;
        at(x); bus.pll_locked = 1'b0;
        e.pll = 1'b1; e.soc = 1'b1; e.rdy = 1'b0; push(x + 3);
        e.pll = 1'b0; push(x + 11);
        w0 = x + 11;
        for (int k = 1; k <= 300; k++) begin
            e.pll = 1'b1; e.fail = k > 255 ? 8'd255 : 8'(k); push(w0 + 72 * k - 8);
            e.pll = 1'b0; push(w0 + 72 * k);
        end
        // Relock, then async reset in SOC_RST clears everything immediately
        k0 = w0 + 72 * 300 + 5;
        at(k0); bus.pll_locked = 1'b1;
        at(k0 + 21);
        e = RST_O; push(k0 + 22);
        #2 reset = 1'b1;
        #1;
        n_tests++;
        if (cur() !== RST_O) begin
            n_fail++;
            $display("FAIL async_reset: got %h want %h", cur(), RST_O);
        end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        q0 = cyc;
        e.pll = 1'b0; push(q0 + 8);
        e.soc = 1'b0; e.rdy = 1'b1; push(q0 + 29);
        at(q0 + 40);
        while (q.size() > 0) begin
            ev_t m;
            m = q.pop_front();
            n_tests++;
            n_fail++;
            $display("FAIL missing_event: no change seen, want cycle %0d outs %h", m.cyc, m.o);
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
